// File: rtl/sram_like_bridge_if.sv
// sram_like_bridge_if: one sram-like request/response channel between the bridge (master) and the AXI side (slave).
interface sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_bridge.sv
// sram_like_bridge: turns the core's single-cycle fetch/memory accesses into sram-like transactions and drives its stalls.
// Optional kseg0/kseg1 address map enabled by defining SRAM_LIKE_ADDR_MAP_EN.
module sram_like_chan #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic              longest_stall,
    input  logic [DATA_W-1:0] rdata,
    output logic              req,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // DONE holds the result until the core's global stall releases, so nothing is re-issued
    always_comb begin
        state_d = state_q == IDLE ? ((en && addr_ok) ? WAIT : IDLE)
                : state_q == WAIT ? (data_ok ? DONE : WAIT)
                : (longest_stall ? DONE : IDLE);
        wr_d    = (state_q == IDLE && en && addr_ok) ? wr : wr_q;
        rdata_d = (state_q == WAIT && data_ok && !wr_q) ? rdata : rdata_q;
    end

    always_comb begin
        req     = state_q == IDLE && en;
        stall   = en && state_q != DONE;
        rdata_o = rdata_q;
    end
endmodule

module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_en,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_rdata_o,
    output logic                inst_stall,
    input  logic                data_en,
    input  logic [3:0]          data_wen,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_stall,
    input  logic                longest_stall,
    sram_like_bridge_if.master  inst_bus,
    sram_like_bridge_if.master  data_bus
);
`ifdef SRAM_LIKE_ADDR_MAP_EN
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: 2] == 2'b10 ? {3'b000, a[ADDR_W-4:0]} : a;
    endfunction
`else
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
        return a;
    endfunction
`endif

    logic [1:0] dsize, dlo;
    logic       unused_lo;

    // low address bits are rebuilt from the byte lanes; the core's own [1:0] are not trusted
    always_comb begin
        {dsize, dlo} = data_wen == 4'b0001 ? {2'd0, 2'd0}
                     : data_wen == 4'b0010 ? {2'd0, 2'd1}
                     : data_wen == 4'b0100 ? {2'd0, 2'd2}
                     : data_wen == 4'b1000 ? {2'd0, 2'd3}
                     : data_wen == 4'b0011 ? {2'd1, 2'd0}
                     : data_wen == 4'b1100 ? {2'd1, 2'd2}
                     : {2'd2, 2'd0};
    end

    assign unused_lo      = ^data_addr_i[1:0];
    assign inst_bus.wr    = 1'b0;
    assign inst_bus.size  = 2'b10;
    assign inst_bus.wdata = '0;
    assign inst_bus.addr  = map_addr(inst_addr_i);
    assign data_bus.wr    = |data_wen;
    assign data_bus.size  = dsize;
    assign data_bus.wdata = data_wdata_i;
    assign data_bus.addr  = map_addr({data_addr_i[ADDR_W-1:2], dlo});

    sram_like_chan #(.DATA_W(DATA_W)) u_inst (
        .clk(clk), .rst(rst), .en(inst_en), .wr(1'b0),
        .addr_ok(inst_bus.addr_ok), .data_ok(inst_bus.data_ok),
        .longest_stall(longest_stall), .rdata(inst_bus.rdata),
        .req(inst_bus.req), .stall(inst_stall), .rdata_o(inst_rdata_o)
    );

    sram_like_chan #(.DATA_W(DATA_W)) u_data (
        .clk(clk), .rst(rst), .en(data_en), .wr(|data_wen),
        .addr_ok(data_bus.addr_ok), .data_ok(data_bus.data_ok),
        .longest_stall(longest_stall), .rdata(data_bus.rdata),
        .req(data_bus.req), .stall(data_stall), .rdata_o(data_rdata_o)
    );
endmodule

// File: tb/tb_sram_like_bridge.sv
// tb_sram_like_bridge: directed and randomized transactions on both channels checked against a transaction-level model.
module tb_sram_like_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en, data_en, longest_stall;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
    logic [3:0]  data_wen;
    logic [31:0] inst_rdata_o, data_rdata_o;
    logic        inst_stall, data_stall;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] exp_inst_rd, exp_data_rd;
    logic [3:0]  wen_pool [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6};

    sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr_i(inst_addr_i), .inst_rdata_o(inst_rdata_o), .inst_stall(inst_stall),
        .data_en(data_en), .data_wen(data_wen), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_stall(data_stall), .longest_stall(longest_stall),
        .inst_bus(inst_bus), .data_bus(data_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vmap(input logic [31:0] a);
`ifdef SRAM_LIKE_ADDR_MAP_EN
        return (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) ? (a & 32'h1FFF_FFFF) : a;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input int aw, input int dw, input logic [31:0] word, input int hold);
        int st = 0;
        inst_en = 1'b1;
        inst_addr_i = addr;
        for (int k = 0; k <= aw; k++) begin
            inst_bus.addr_ok = (k == aw);
            #1;
            chk("i_req", {31'd0, inst_bus.req}, 1);
            chk("i_addr", inst_bus.addr, vmap(addr));
            chk("i_size_wr", {29'd0, inst_bus.size, inst_bus.wr}, 32'd4);
            chk("i_wdata", inst_bus.wdata, 0);
            st += int'(inst_stall);
            tick();
        end
        inst_bus.addr_ok = 1'b0;
        for (int k = 0; k <= dw; k++) begin
            inst_bus.data_ok = (k == dw);
            inst_bus.rdata = (k == dw) ? word : $urandom;
            #1;
            chk("i_req_wait", {31'd0, inst_bus.req}, 0);
            st += int'(inst_stall);
            tick();
        end
        inst_bus.data_ok = 1'b0;
        inst_bus.rdata = $urandom;
        exp_inst_rd = word;
        longest_stall = 1'b1;
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("i_hold_stall", {31'd0, inst_stall}, 0);
            chk("i_hold_req", {31'd0, inst_bus.req}, 0);
            chk("i_hold_rdata", inst_rdata_o, exp_inst_rd);
            tick();
        end
        longest_stall = 1'b0;
        #1;
        chk("i_done_stall", {31'd0, inst_stall}, 0);
        chk("i_done_rdata", inst_rdata_o, exp_inst_rd);
        tick();
        inst_en = 1'b0;
        #1;
        chk("i_stall_cycles", st, aw + dw + 2);
        chk("i_idle_req", {31'd0, inst_bus.req}, 0);
    endtask

    task automatic mem(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                       input int aw, input int dw, input logic [31:0] word, input int hold);
        logic [1:0]  es;
        logic [31:0] ea;
        int          st = 0;
        es = 2'd2;
        ea = {addr[31:2], 2'b00};
        if ($countones(wen) == 1) begin
            es = 2'd0;
            for (int b = 0; b < 4; b++) if (wen[b]) ea[1:0] = b[1:0];
        end else if (wen == 4'b0011) es = 2'd1;
        else if (wen == 4'b1100) begin
            es = 2'd1;
            ea[1:0] = 2'b10;
        end
        ea = vmap(ea);
        data_en = 1'b1;
        data_wen = wen;
        data_addr_i = addr;
        data_wdata_i = wd;
        for (int k = 0; k <= aw; k++) begin
            data_bus.addr_ok = (k == aw);
            #1;
            chk("d_req", {31'd0, data_bus.req}, 1);
            chk("d_addr", data_bus.addr, ea);
            chk("d_size", {30'd0, data_bus.size}, {30'd0, es});
            chk("d_wr", {31'd0, data_bus.wr}, {31'd0, wen != 4'd0});
            chk("d_wdata", data_bus.wdata, wd);
            st += int'(data_stall);
            tick();
        end
        data_bus.addr_ok = 1'b0;
        for (int k = 0; k <= dw; k++) begin
            data_bus.data_ok = (k == dw);
            data_bus.rdata = (k == dw) ? word : $urandom;
            #1;
            chk("d_req_wait", {31'd0, data_bus.req}, 0);
            st += int'(data_stall);
            tick();
        end
        data_bus.data_ok = 1'b0;
        data_bus.rdata = $urandom;
        if (wen == 4'd0) exp_data_rd = word;
        longest_stall = 1'b1;
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("d_hold_stall", {31'd0, data_stall}, 0);
            chk("d_hold_req", {31'd0, data_bus.req}, 0);
            chk("d_hold_rdata", data_rdata_o, exp_data_rd);
            tick();
        end
        longest_stall = 1'b0;
        #1;
        chk("d_done_stall", {31'd0, data_stall}, 0);
        chk("d_done_rdata", data_rdata_o, exp_data_rd);
        tick();
        data_en = 1'b0;
        data_wen = 4'd0;
        #1;
        chk("d_stall_cycles", st, aw + dw + 2);
        chk("d_idle_req", {31'd0, data_bus.req}, 0);
    endtask

    initial begin
        rst = 1'b0;
        inst_en = 1'b0; data_en = 1'b0; longest_stall = 1'b0;
        inst_addr_i = '0; data_addr_i = '0; data_wdata_i = '0; data_wen = 4'd0;
        inst_bus.addr_ok = 1'b0; inst_bus.data_ok = 1'b0; inst_bus.rdata = '0;
        data_bus.addr_ok = 1'b0; data_bus.data_ok = 1'b0; data_bus.rdata = '0;
        exp_inst_rd = '0; exp_data_rd = '0;
        #2;
        chk("rst_reqs", {30'd0, inst_bus.req, data_bus.req}, 0);
        chk("rst_wrs", {30'd0, inst_bus.wr, data_bus.wr}, 0);
        chk("rst_stalls", {30'd0, inst_stall, data_stall}, 0);
        chk("rst_i_rdata", inst_rdata_o, 0);
        chk("rst_d_rdata", data_rdata_o, 0);
        tick();
        rst = 1'b1;
        tick();

        fetch(32'h0000_0100, 0, 0, 32'h2408_0001, 0);
        fetch(32'h0000_0200, 3, 0, 32'h3C01_BFC0, 0);
        fetch(32'hBFC0_0000, 0, 2, 32'h0000_0000, 1);
        fetch(32'h8000_1234, 1, 1, 32'hDEAD_0001, 0);

        mem(4'b0000, 32'h0000_2000, 32'h0, 0, 0, 32'hCAFE_BABE, 4);
        mem(4'b0100, 32'h0000_1004, 32'h00AB_0000, 0, 0, 32'h1111_1111, 0);
        mem(4'b1100, 32'h0000_1004, 32'hABCD_0000, 1, 0, 32'h2222_2222, 1);
        mem(4'b1111, 32'h0000_1004, 32'h1234_5678, 0, 2, 32'h3333_3333, 0);
        mem(4'b0011, 32'hA000_1006, 32'h0000_5678, 0, 0, 32'h4444_4444, 0);

        data_en = 1'b1;
        data_wen = 4'd0;
        data_addr_i = 32'h0000_3000;
        data_bus.addr_ok = 1'b1;
        #1;
        tick();
        data_bus.addr_ok = 1'b0;
        #1;
        chk("rw_wait_stall", {31'd0, data_stall}, 1);
        rst = 1'b0;
        data_en = 1'b0;
        #1;
        chk("rw_req", {31'd0, data_bus.req}, 0);
        chk("rw_rdata", data_rdata_o, 0);
        chk("rw_stall", {31'd0, data_stall}, 0);
        tick();
        rst = 1'b1;
        exp_data_rd = '0;
        data_bus.data_ok = 1'b1;
        data_bus.rdata = 32'h5555_AAAA;
        tick();
        data_bus.data_ok = 1'b0;
        tick();
        chk("rw_late_rdata", data_rdata_o, 0);
        chk("rw_late_req", {31'd0, data_bus.req}, 0);
        mem(4'b0000, 32'h0000_3000, 32'h0, 0, 0, 32'h7777_8888, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
            else
                mem(wen_pool[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
